// File: rtl/shared_match_req_dispatcher.sv
// Routes match requests to the owning shared match PE slice over the mesh and returns responses.
// Optional DISPATCH_PERF_CNT_EN adds request and stall performance counters.
module shared_match_req_dispatcher #(
  parameter int ADDR_WIDTH       = 24,
  parameter int TAG_BITS         = 6,
  parameter int MATCH_LEN_WIDTH  = 6,
  parameter int MESH_W           = 64,
  parameter int MESH_X_SIZE_LOG2 = 2,
  parameter int MESH_Y_SIZE_LOG2 = 2,
  parameter int SLICE_SIZE_LOG2  = 16,
  parameter int NUM_SLICE_LOG2   = 3,
  parameter int MESH_Y_BASE      = 2,
  parameter int MAX_OUTSTANDING  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        match_req_valid,
  output logic                        match_req_ready,
  input  logic [ADDR_WIDTH-1:0]       match_req_head_addr,
  input  logic [ADDR_WIDTH-1:0]       match_req_history_addr,
  input  logic [TAG_BITS-1:0]         match_req_tag,
  output logic                        to_mesh_valid,
  input  logic                        to_mesh_ready,
  output logic [MESH_X_SIZE_LOG2-1:0] to_mesh_x_dst,
  output logic [MESH_Y_SIZE_LOG2-1:0] to_mesh_y_dst,
  output logic [MESH_W-1:0]           to_mesh_payload,
  input  logic                        from_mesh_valid,
  output logic                        from_mesh_ready,
  input  logic [MESH_W-1:0]           from_mesh_payload,
  output logic                        match_resp_valid,
  input  logic                        match_resp_ready,
  output logic [TAG_BITS-1:0]         match_resp_tag,
  output logic [MATCH_LEN_WIDTH-1:0]  match_resp_match_len,
  output logic [7:0]                  outstanding,
  output logic                        err_underflow
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_req_cnt,
  output logic [31:0]                 perf_stall_cnt
`endif
);

  localparam logic [7:0] MAX_OUT = 8'(MAX_OUTSTANDING);

  logic [NUM_SLICE_LOG2-1:0]   slice_idx;
  logic [31:0]                 idx_ext;
  logic [31:0]                 y_sum;
  logic [MESH_X_SIZE_LOG2-1:0] x_next;
  logic [MESH_Y_SIZE_LOG2-1:0] y_next;
  logic [MESH_W-1:0]           req_flit;
  logic                        out_free;
  logic                        req_accept;
  logic                        resp_hs;
  logic                        unused_bits;

  assign slice_idx = match_req_history_addr[SLICE_SIZE_LOG2 +: NUM_SLICE_LOG2];
  assign idx_ext   = 32'(slice_idx);
  assign x_next    = idx_ext[MESH_X_SIZE_LOG2-1:0];
  // Row offset wraps modulo the mesh height.
  assign y_sum     = 32'(MESH_Y_BASE) + (idx_ext >> MESH_X_SIZE_LOG2);
  assign y_next    = y_sum[MESH_Y_SIZE_LOG2-1:0];

  always_comb begin
    req_flit = '0;
    req_flit[ADDR_WIDTH-1:0]             = match_req_head_addr;
    req_flit[ADDR_WIDTH +: ADDR_WIDTH]   = match_req_history_addr;
    req_flit[2*ADDR_WIDTH +: TAG_BITS]   = match_req_tag;
  end

  assign out_free        = !to_mesh_valid || to_mesh_ready;
  assign match_req_ready = out_free && (outstanding < MAX_OUT);
  assign req_accept      = match_req_valid && match_req_ready;
  assign from_mesh_ready = !match_resp_valid || match_resp_ready;
  assign resp_hs         = from_mesh_valid && from_mesh_ready;

  assign unused_bits = ^{from_mesh_payload[MESH_W-1:MATCH_LEN_WIDTH+TAG_BITS],
                         y_sum[31:MESH_Y_SIZE_LOG2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      to_mesh_valid   <= 1'b0;
      to_mesh_x_dst   <= '0;
      to_mesh_y_dst   <= '0;
      to_mesh_payload <= '0;
    end else if (out_free) begin
      to_mesh_valid <= req_accept;
      if (req_accept) begin
        to_mesh_x_dst   <= x_next;
        to_mesh_y_dst   <= y_next;
        to_mesh_payload <= req_flit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match_resp_valid     <= 1'b0;
      match_resp_tag       <= '0;
      match_resp_match_len <= '0;
    end else if (from_mesh_ready) begin
      match_resp_valid <= from_mesh_valid;
      if (from_mesh_valid) begin
        match_resp_tag       <= from_mesh_payload[MATCH_LEN_WIDTH +: TAG_BITS];
        match_resp_match_len <= from_mesh_payload[MATCH_LEN_WIDTH-1:0];
      end
    end
  end

  // A response with no credit in flight is flagged and leaves the counter at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({req_accept, resp_hs})
        2'b10: outstanding <= outstanding + 8'd1;
        2'b01: begin
          if (outstanding == 8'd0) err_underflow <= 1'b1;
          else                     outstanding   <= outstanding - 8'd1;
        end
        default: outstanding <= outstanding;
      endcase
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (req_accept) perf_req_cnt <= perf_req_cnt + 32'd1;
      if (match_req_valid && !match_req_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_shared_match_req_dispatcher.sv
// Scoreboard bench for shared_match_req_dispatcher: randomized and directed traffic against a reference model.
module tb_shared_match_req_dispatcher;

  typedef struct {
    logic [63:0] payload;
    logic [1:0]  x;
    logic [1:0]  y;
    logic [5:0]  tag;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        match_req_valid = 1'b0;
  logic        match_req_ready;
  logic [23:0] match_req_head_addr = '0;
  logic [23:0] match_req_history_addr = '0;
  logic [5:0]  match_req_tag = '0;
  logic        to_mesh_valid;
  logic        to_mesh_ready = 1'b0;
  logic [1:0]  to_mesh_x_dst;
  logic [1:0]  to_mesh_y_dst;
  logic [63:0] to_mesh_payload;
  logic        from_mesh_valid = 1'b0;
  logic        from_mesh_ready;
  logic [63:0] from_mesh_payload = '0;
  logic        match_resp_valid;
  logic        match_resp_ready = 1'b0;
  logic [5:0]  match_resp_tag;
  logic [5:0]  match_resp_match_len;
  logic [7:0]  outstanding;
  logic        err_underflow;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_req_cnt;
  logic [31:0] perf_stall_cnt;
  longint      model_perf_req = 0;
  longint      model_perf_stall = 0;
`endif

  req_t        req_q[$];
  logic [11:0] resp_q[$];
  logic [63:0] pending_q[$];
  int          model_out = 0;
  bit          model_err = 0;
  bit          from_pending = 0;
  int          len_override = -1;
  int          checks = 0;
  int          errors = 0;

  shared_match_req_dispatcher dut (
    .clk(clk), .rst(rst),
    .match_req_valid(match_req_valid), .match_req_ready(match_req_ready),
    .match_req_head_addr(match_req_head_addr), .match_req_history_addr(match_req_history_addr),
    .match_req_tag(match_req_tag),
    .to_mesh_valid(to_mesh_valid), .to_mesh_ready(to_mesh_ready),
    .to_mesh_x_dst(to_mesh_x_dst), .to_mesh_y_dst(to_mesh_y_dst), .to_mesh_payload(to_mesh_payload),
    .from_mesh_valid(from_mesh_valid), .from_mesh_ready(from_mesh_ready),
    .from_mesh_payload(from_mesh_payload),
    .match_resp_valid(match_resp_valid), .match_resp_ready(match_resp_ready),
    .match_resp_tag(match_resp_tag), .match_resp_match_len(match_resp_match_len),
    .outstanding(outstanding), .err_underflow(err_underflow)
`ifdef DISPATCH_PERF_CNT_EN
    , .perf_req_cnt(perf_req_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference routing: slice index from the history address, mesh coords by plain arithmetic.
  function automatic req_t make_req(input logic [23:0] head, input logic [23:0] hist, input logic [5:0] tag);
    req_t r;
    int idx;
    idx = (int'(hist) / 65536) % 8;
    r.x = 2'(idx % 4);
    r.y = 2'((2 + idx / 4) % 4);
    r.payload = 64'(head) + 64'(hist) * 64'h1000000 + 64'(tag) * 64'h1000000000000;
    r.tag = tag;
    return r;
  endfunction

  always @(negedge clk) begin
    bit exp_ready, acc, hs, resp_free;
    req_t r;
    logic [63:0] rp;
    if (rst) begin
      req_q.delete(); resp_q.delete(); pending_q.delete();
      model_out = 0; model_err = 0;
`ifdef DISPATCH_PERF_CNT_EN
      model_perf_req = 0; model_perf_stall = 0;
`endif
    end else begin
      exp_ready = (req_q.size() == 0 || to_mesh_ready) && model_out < 8;
      resp_free = resp_q.size() == 0 || match_resp_ready;
      checkOutput("match_req_ready", 64'(match_req_ready), 64'(exp_ready));
      checkOutput("outstanding", 64'(outstanding), 64'(model_out));
      checkOutput("err_underflow", 64'(err_underflow), 64'(model_err));
      checkOutput("to_mesh_valid", 64'(to_mesh_valid), 64'(req_q.size() != 0));
      if (req_q.size() != 0 && to_mesh_valid) begin
        checkOutput("to_mesh_payload", to_mesh_payload, req_q[0].payload);
        checkOutput("to_mesh_x_dst", 64'(to_mesh_x_dst), 64'(req_q[0].x));
        checkOutput("to_mesh_y_dst", 64'(to_mesh_y_dst), 64'(req_q[0].y));
      end
      checkOutput("from_mesh_ready", 64'(from_mesh_ready), 64'(resp_free));
      checkOutput("match_resp_valid", 64'(match_resp_valid), 64'(resp_q.size() != 0));
      if (resp_q.size() != 0 && match_resp_valid) begin
        checkOutput("match_resp_tag", 64'(match_resp_tag), 64'(resp_q[0][11:6]));
        checkOutput("match_resp_len", 64'(match_resp_match_len), 64'(resp_q[0][5:0]));
      end
`ifdef DISPATCH_PERF_CNT_EN
      checkOutput("perf_req_cnt", 64'(perf_req_cnt), 64'(model_perf_req % 64'h100000000));
      checkOutput("perf_stall_cnt", 64'(perf_stall_cnt), 64'(model_perf_stall % 64'h100000000));
`endif
      acc = match_req_valid && exp_ready;
      hs  = from_mesh_valid && resp_free;
`ifdef DISPATCH_PERF_CNT_EN
      if (acc) model_perf_req++;
      if (match_req_valid && !exp_ready) model_perf_stall++;
`endif
      if (req_q.size() != 0 && to_mesh_ready) begin
        r = req_q.pop_front();
        rp = {$urandom(), $urandom()};
        rp[11:6] = r.tag;
        if (len_override >= 0) rp[5:0] = 6'(len_override);
        pending_q.push_back(rp);
      end
      if (resp_q.size() != 0 && match_resp_ready) void'(resp_q.pop_front());
      if (acc) req_q.push_back(make_req(match_req_head_addr, match_req_history_addr, match_req_tag));
      if (hs) begin
        resp_q.push_back(from_mesh_payload[11:0]);
        if (from_pending && pending_q.size() != 0) void'(pending_q.pop_front());
      end
      if (acc && !hs) model_out++;
      else if (!acc && hs) begin
        if (model_out == 0) model_err = 1;
        else model_out--;
      end
    end
  end

  task automatic applyStimulus(input bit rv, input logic [23:0] head, input logic [23:0] hist,
                               input logic [5:0] tag, input bit tmr, input bit fmv, input bit mrr);
    @(posedge clk); #1;
    match_req_valid = rv;
    match_req_head_addr = head;
    match_req_history_addr = hist;
    match_req_tag = tag;
    to_mesh_ready = tmr;
    match_resp_ready = mrr;
    if (fmv && pending_q.size() != 0) begin
      from_mesh_valid = 1'b1;
      from_mesh_payload = pending_q[0];
      from_pending = 1'b1;
    end else begin
      from_mesh_valid = 1'b0;
      from_pending = 1'b0;
    end
  endtask

  task automatic injectResp(input logic [63:0] payload);
    @(posedge clk); #1;
    match_req_valid = 1'b0;
    to_mesh_ready = 1'b1;
    match_resp_ready = 1'b1;
    from_mesh_valid = 1'b1;
    from_mesh_payload = payload;
    from_pending = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, '0, 1, 0, 1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((model_out != 0 || req_q.size() != 0 || resp_q.size() != 0) && budget < 300) begin
      applyStimulus(0, '0, '0, '0, 1, 1, 1);
      budget++;
    end
    if (budget >= 300) checkOutput("drain_timeout", 64'(model_out), 64'd0);
    idle(2);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    match_req_valid = 1'b0;
    from_mesh_valid = 1'b0;
    from_pending = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    doReset();
    idle(2);

    applyStimulus(1, 24'h051300, 24'h051234, 6'h2A, 1, 0, 1);
    idle(2);
    applyStimulus(1, 24'h000010, 24'h070000, 6'h01, 1, 0, 1);
    applyStimulus(1, 24'h000020, 24'h0F1234, 6'h02, 1, 0, 1);
    applyStimulus(1, 24'h000030, 24'h0C0000, 6'h03, 1, 0, 1);
    drain();

    for (int i = 0; i < 8; i++) applyStimulus(1, 24'(i), 24'(i * 65536), 6'(i), 1, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1, 24'h111111, 24'h222222, 6'h3F, 1, 0, 1);
    applyStimulus(1, 24'h111111, 24'h222222, 6'h3F, 1, 1, 1);
    applyStimulus(1, 24'h333333, 24'h444444, 6'h15, 1, 0, 1);
    applyStimulus(0, '0, '0, '0, 1, 0, 1);
    drain();

    applyStimulus(1, 24'hABCDEF, 24'h123456, 6'h07, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 24'h0A0A0A, 24'h050505, 6'h08, 0, 0, 1);
    applyStimulus(1, 24'h0A0A0A, 24'h050505, 6'h08, 1, 0, 1);
    applyStimulus(0, '0, '0, '0, 1, 0, 1);
    drain();

    for (int i = 0; i < 3; i++) applyStimulus(1, 24'(i + 5), 24'(i * 131072), 6'(i + 9), 1, 0, 1);
    applyStimulus(0, '0, '0, '0, 1, 0, 1);
    applyStimulus(1, 24'h777777, 24'h060000, 6'h0C, 1, 1, 1);
    drain();

    len_override = 'h20;
    applyStimulus(1, 24'h000001, 24'h010000, 6'h11, 1, 0, 1);
    applyStimulus(0, '0, '0, '0, 1, 0, 0);
    applyStimulus(1, '0, '0, '0, 1, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, '0, '0, '0, 1, 0, 0);
    len_override = -1;
    drain();

    injectResp(64'hFFFF_FFFF_FFFF_F7A5);
    idle(3);
    drain();

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 99) < 70, 24'($urandom()), 24'($urandom()), 6'($urandom()),
                    $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70);
      if (i == 200) doReset();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shared_match_req_dispatcher.md
Name: shared_match_req_dispatcher

Overview:
Job-PE-side stage directly upstream of the shared match PE clusters. Accepts match requests, routes each to the cluster slice owning its history address, and packs the request into a mesh flit. Returns the mesh response flits (tag, match_len) to the job PE. Bounds in-flight requests with an outstanding counter.

Parameters:
ADDR_WIDTH, 24, byte address width of head/history addresses
TAG_BITS, 6, request tag width (job PE idx + lazy slot)
MATCH_LEN_WIDTH, 6, match length width
MESH_W, 64, mesh payload width; must be >= 2*ADDR_WIDTH+TAG_BITS and >= TAG_BITS+MATCH_LEN_WIDTH
MESH_X_SIZE_LOG2, 2, mesh x coordinate width
MESH_Y_SIZE_LOG2, 2, mesh y coordinate width
SLICE_SIZE_LOG2, 16, log2 bytes of history held per slice
NUM_SLICE_LOG2, 3, log2 number of shared match PE slices
MESH_Y_BASE, 2, mesh row of slice 0
MAX_OUTSTANDING, 8, max in-flight requests (1..255)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active high
match_req_valid  input  1  request valid
match_req_ready  output  1  request accepted when valid&ready
match_req_head_addr  input  ADDR_WIDTH  lookahead address
match_req_history_addr  input  ADDR_WIDTH  candidate history address
match_req_tag  input  TAG_BITS  request tag
to_mesh_valid  output  1  flit valid
to_mesh_ready  input  1  mesh accepts flit
to_mesh_x_dst  output  MESH_X_SIZE_LOG2  destination column
to_mesh_y_dst  output  MESH_Y_SIZE_LOG2  destination row
to_mesh_payload  output  MESH_W  request flit
from_mesh_valid  input  1  response flit valid
from_mesh_ready  output  1  response flit accepted
from_mesh_payload  input  MESH_W  response flit
match_resp_valid  output  1  response valid
match_resp_ready  input  1  job PE accepts response
match_resp_tag  output  TAG_BITS  response tag
match_resp_match_len  output  MATCH_LEN_WIDTH  match length
outstanding  output  8  current in-flight count
err_underflow  output  1  sticky: response arrived with outstanding==0

Behaviour:
- Reset values: to_mesh_valid=0, match_resp_valid=0, outstanding=0, err_underflow=0; data regs 0. Reset mid-operation drops held flits/responses and clears the counter.
- Slice idx = history_addr[SLICE_SIZE_LOG2 +: NUM_SLICE_LOG2]; x_dst = idx[MESH_X_SIZE_LOG2-1:0]; y_dst = (MESH_Y_BASE + (idx >> MESH_X_SIZE_LOG2)) truncated to MESH_Y_SIZE_LOG2 (wraps modulo).
- Request flit, LSB first: [ADDR_WIDTH-1:0]=head_addr, next ADDR_WIDTH=history_addr, next TAG_BITS=tag, rest zero.
- Request stage: single output register. match_req_ready = (!to_mesh_valid | to_mesh_ready) & (outstanding < MAX_OUTSTANDING). On accept, flit/dst registered; to_mesh_valid high next cycle (latency 1). Flit and dst stable while valid&!ready. Full throughput: 1 req/cycle when mesh ready and credits available.
- Response flit: match_len=[MATCH_LEN_WIDTH-1:0], tag=[MATCH_LEN_WIDTH +: TAG_BITS]. Single output register; from_mesh_ready = !match_resp_valid | match_resp_ready; latency 1; data stable while stalled.
- outstanding: +1 on request accept, -1 on from_mesh handshake, unchanged when both in the same cycle. Handshake at outstanding==0 with no simultaneous accept: counter stays 0, err_underflow set until reset. At MAX_OUTSTANDING, match_req_ready=0; a response in that cycle frees a credit from the next cycle (no combinational ready from from_mesh_valid).

Optional Feature:
DISPATCH_PERF_CNT_EN: when defined, adds outputs perf_req_cnt (32b, +1 per request accept) and perf_stall_cnt (32b, +1 per cycle with match_req_valid & !match_req_ready); both reset to 0 and wrap at 2^32. When undefined, ports and logic absent; other behaviour identical.

Test Plan:
- history_addr=0x051234, head=0x051300, tag=0x2A, mesh ready -> next cycle to_mesh_valid=1, x_dst=1, y_dst=3, payload[23:0]=0x051300, [47:24]=0x051234, [53:48]=0x2A, [63:54]=0.
- history_addr with idx=7 -> x_dst=3, y_dst=(2+1)=3; idx=12 unreachable with default NUM_SLICE_LOG2=3 -> check idx bits masked.
- 8 requests, no responses -> outstanding=8, match_req_ready=0; one response -> ready=1 following cycle, outstanding=7.
- to_mesh_ready=0 for 5 cycles with valid flit -> payload/dst unchanged, match_req_ready=0; release -> flit sent once, next request accepted same cycle.
- Request accept and response same cycle at outstanding=3 -> remains 3; response at outstanding=0 -> err_underflow=1 sticky, outstanding=0; rst -> all cleared.
- Response payload {tag=0x11,len=0x20} with match_resp_ready=0 three cycles -> match_resp_tag=0x11, len=0x20 held, from_mesh_ready=0; under DISPATCH_PERF_CNT_EN stall cycles counted exactly.
